pc_sequencer: RTL

//   Registered, parametrised program-counter unit; successor to the combinational next-PC selector.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/pc_target_sel.sv | 58 +++++
 rtl/pc_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : shared CPU constants and PC sequencer state encodings      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;
  localparam int C_XLEN    = 32;
  localparam int C_PC_STEP = 4;

  localparam logic [1:0] C_ST_BOOT = 2'd0;
  localparam logic [1:0] C_ST_RUN  = 2'd1;
  localparam logic [1:0] C_ST_HALT = 2'd2;
endpackage
`default_nettype wire

// File: rtl/pc_target_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_target_sel : priority redirect select and target adders.          |
// | TRAP_EN adds trap_i/trap_vec_i as the top-priority redirect.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pc_target_sel
  import cpu_pkg::*;
#(
  parameter int XLEN = C_XLEN
) (
`ifdef TRAP_EN
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
`endif
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic            is_branch_i,
  input  logic            branch_taken_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] target_o
);
  logic [XLEN-1:0] w_pc_rel;
  logic [XLEN-1:0] w_reg_rel;
  logic [XLEN-1:0] w_sel;

  assign w_pc_rel  = ex_pc_i + imm_i;
  assign w_reg_rel = rs1_data_i + imm_i;

  always_comb begin
    redirect_o = 1'b0;
    w_sel      = '0;
`ifdef TRAP_EN
    if (trap_i) begin
      redirect_o = 1'b1;
      w_sel      = trap_vec_i;
    end else
`endif
    if (ex_valid_i && is_jalr_i) begin
      redirect_o = 1'b1;
      w_sel      = w_reg_rel;
    end else if (ex_valid_i && is_jal_i) begin
      redirect_o = 1'b1;
      w_sel      = w_pc_rel;
    end else if (ex_valid_i && is_branch_i && branch_taken_i) begin
      redirect_o = 1'b1;
      w_sel      = w_pc_rel;
    end
  end

  // Bit 0 is cleared for every target so the fetch PC is always halfword aligned.
  assign target_o = w_sel & ~XLEN'(1);
endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_sequencer : registered fetch PC with valid/ready, redirects and   |
// | halt/resume. Define TRAP_EN to add the trap redirect ports.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              XLEN      = C_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              PC_STEP   = C_PC_STEP
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef TRAP_EN
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
`endif
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  input  logic            pc_ready_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic            is_branch_i,
  input  logic            branch_taken_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  input  logic            halt_i,
  output logic            redirect_o,
  output logic            misalign_o
);
  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic            r_redirect;
  logic            r_misalign;
  logic            w_redirect;
  logic [XLEN-1:0] w_target;

  pc_target_sel #(
    .XLEN(XLEN)
  ) u_target_sel (
`ifdef TRAP_EN
    .trap_i        (trap_i),
    .trap_vec_i    (trap_vec_i),
`endif
    .ex_valid_i    (ex_valid_i),
    .ex_pc_i       (ex_pc_i),
    .imm_i         (imm_i),
    .rs1_data_i    (rs1_data_i),
    .is_branch_i   (is_branch_i),
    .branch_taken_i(branch_taken_i),
    .is_jal_i      (is_jal_i),
    .is_jalr_i     (is_jalr_i),
    .redirect_o    (w_redirect),
    .target_o      (w_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= C_ST_BOOT;
    else        r_state <= w_state_nxt;
  end

  // Halt is only taken once the offered PC is consumed or superseded by a redirect.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_BOOT: w_state_nxt = C_ST_RUN;
      C_ST_RUN:  if (halt_i && (pc_ready_i || w_redirect)) w_state_nxt = C_ST_HALT;
      C_ST_HALT: if (!halt_i) w_state_nxt = C_ST_RUN;
      default:   w_state_nxt = C_ST_BOOT;
    endcase
  end

  always_comb begin
    pc_valid_o = (r_state == C_ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_VEC;
      r_redirect <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_redirect <= w_redirect;
      r_misalign <= w_redirect && w_target[1];
      if (w_redirect)
        r_pc <= w_target;
      else if ((r_state == C_ST_RUN) && pc_ready_i)
        r_pc <= r_pc + XLEN'(PC_STEP);
    end
  end

  assign pc_o       = r_pc;
  assign redirect_o = r_redirect;
  assign misalign_o = r_misalign;
endmodule
`default_nettype wire
